// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state type,
// architectural constants and a word-alignment helper.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0 -- presented whenever no live instruction is held
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH,  // issue one request at pc_q
    ST_WAIT,   // request outstanding, response wanted
    ST_DRAIN,  // request outstanding, response stale and to be dropped
    ST_HOLD    // instruction presented, waiting for downstream to take it
  } fetch_state_e;

  // Force the two low address bits to zero.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read port.
//   req    : one-cycle read request
//   addr   : word-aligned read address, qualified by req
//   rvalid : read data valid, at earliest the cycle after req
//   rdata  : read data, qualified by rvalid
// master = fetch unit side, slave = memory side.
interface fetch_if;
  import fetch_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input rvalid, rdata);
  modport slave  (input req, addr, output rvalid, rdata);

endinterface

// File: rtl/fetch_unit.sv
// Non-prefetching instruction fetch unit with a single outstanding request.
// Requests one word, waits for it, presents it until downstream accepts it,
// then requests the next word. Redirects override everything except reset;
// a request that is still in flight when redirected is drained and dropped.
//
// Ports
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_stall            : downstream not accepting the presented instruction
//   i_redirect         : taken branch/jump from a later stage
//   i_redirect_pc      : redirect target (low two bits ignored)
//   imem               : instruction-memory read port (master side)
//   o_instr            : fetched instruction, NOP when o_valid is low
//   o_pc, o_pc_four    : PC of the presented instruction and PC+4
//   o_valid            : o_instr/o_pc/o_pc_four hold a live instruction
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  fetch_if.master         imem,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_four,
  output logic            o_valid
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;

  // Modulo-2^32 increment; wraps silently at the top of the address space.
  assign pc_plus4    = pc_q + XLEN'(4);
  assign redirect_pc = align_word(i_redirect_pc);

  // The request is a pure decode of the FETCH state so it lasts exactly one
  // cycle; it is masked while reset is held.
  assign imem.req  = (state_q == ST_FETCH) && !i_rst;
  assign imem.addr = pc_q;

  // Fetch sequencing, PC and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= align_word(RESET_PC);
      o_valid   <= 1'b0;
      o_instr   <= NOP_INSTR;
      o_pc      <= '0;
      o_pc_four <= '0;
    end else if (i_redirect) begin
      pc_q    <= redirect_pc;
      o_valid <= 1'b0;
      o_instr <= NOP_INSTR;
      unique case (state_q)
        // The request issued this cycle is now stale.
        ST_FETCH: state_q <= ST_DRAIN;
        // A response landing with the redirect is simply dropped; otherwise
        // it is still coming and must be drained.
        ST_WAIT:  state_q <= imem.rvalid ? ST_FETCH : ST_DRAIN;
        // A second redirect while draining keeps the single pending discard,
        // unless that response is arriving right now.
        ST_DRAIN: state_q <= imem.rvalid ? ST_FETCH : ST_DRAIN;
        ST_HOLD:  state_q <= ST_FETCH;
        default:  state_q <= ST_FETCH;
      endcase
    end else begin
      unique case (state_q)
        ST_FETCH: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (imem.rvalid) begin
            o_instr   <= imem.rdata;
            o_pc      <= pc_q;
            o_pc_four <= pc_plus4;
            o_valid   <= 1'b1;
            state_q   <= ST_HOLD;
          end
        end
        ST_DRAIN: begin
          if (imem.rvalid) begin
            state_q <= ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (!i_stall) begin
            pc_q    <= pc_plus4;
            o_valid <= 1'b0;
            o_instr <= NOP_INSTR;
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written redirect/reset
// sequences, then randomized traffic checked against a transaction-level model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        i_rst;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;
  logic        o_valid;

  fetch_if imem ();

  fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_stall      (i_stall),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .imem         (imem),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .o_pc_four    (o_pc_four),
    .o_valid      (o_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int          mem_cnt = 0;
  int          mem_lat = 1;
  logic [31:0] mem_addr = '0;
  bit          rand_lat = 1'b0;
  bit          spurious = 1'b0;

  // ---------------- reference model ----------------
  // Tracks "request outstanding", "outstanding response is stale" and
  // "instruction held" as independent facts.
  bit          m_known = 1'b0;
  bit          m_out, m_drop, m_have;
  logic [31:0] m_pc, m_instr, m_opc, m_ofour;

  function automatic bit m_req();
    return !i_rst && !m_out && !m_have;
  endfunction

  task automatic model_update();
    bit          issued;
    bit          resp;
    bit          nout;
    issued = !m_out && !m_have;
    if (i_rst) begin
      m_pc = {TB_RESET_PC[31:2], 2'b00};
      m_out = 0; m_drop = 0; m_have = 0;
      m_instr = NOP_INSTR; m_opc = '0; m_ofour = '0;
      m_known = 1'b1;
    end else begin
      resp = imem.rvalid && m_out;
      nout = (m_out && !resp) || issued;
      if (i_redirect) begin
        m_pc   = {i_redirect_pc[31:2], 2'b00};
        m_have = 0;
        m_drop = nout;
      end else begin
        if (resp && !m_drop) begin
          m_have  = 1;
          m_instr = imem.rdata;
          m_opc   = m_pc;
          m_ofour = m_pc + 32'd4;
        end else if (m_have && !i_stall) begin
          m_have = 0;
          m_pc   = m_pc + 32'd4;
        end
        if (resp) m_drop = 0;
      end
      m_out = nout;
    end
  endtask

  task automatic model_check(input string tag);
    if (m_known) begin
      chk({tag, ".req"}, 32'(imem.req), 32'(m_req()));
      if (m_req()) chk({tag, ".addr"}, imem.addr, m_pc);
      chk({tag, ".valid"}, 32'(o_valid), 32'(m_have));
      chk({tag, ".instr"}, o_instr, m_have ? m_instr : NOP_INSTR);
      chk({tag, ".pc"}, o_pc, m_opc);
      chk({tag, ".pc4"}, o_pc_four, m_ofour);
    end
  endtask

  // ---------------- cycle driver ----------------
  // Drive inputs shortly after the rising edge, let them settle.
  task automatic drive(input logic rst, input logic stall, input logic redir,
                       input logic [31:0] rpc);
    i_rst = rst; i_stall = stall; i_redirect = redir; i_redirect_pc = rpc;
    if (mem_cnt == 1) begin
      imem.rvalid = 1'b1;
      imem.rdata  = mem_data(mem_addr);
    end else if (spurious && mem_cnt == 0 && $urandom_range(0, 15) == 0) begin
      imem.rvalid = 1'b1;
      imem.rdata  = $urandom;
    end else begin
      imem.rvalid = 1'b0;
      imem.rdata  = $urandom;
    end
    #1;
  endtask

  // Take the edge: update model and memory from this cycle's values.
  task automatic advance();
    logic        s_req;
    logic [31:0] s_addr;
    s_req  = imem.req;
    s_addr = imem.addr;
    model_update();
    @(posedge clk);
    #1;
    if (i_rst) begin
      mem_cnt = 0;
    end else begin
      if (mem_cnt > 0) mem_cnt--;
      if (s_req) begin
        mem_cnt  = mem_lat;
        mem_addr = s_addr;
      end
    end
    if (rand_lat) mem_lat = $urandom_range(1, 4);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc, four;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic stall, input logic redir,
                              input logic [31:0] rpc, input logic c, input logic req,
                              input logic [31:0] addr, input logic valid,
                              input logic [31:0] pc, input logic [31:0] four);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc; v.chk = c;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.four = four;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag, input int lat);
    drive(v.rst, v.stall, v.redir, v.rpc);
    if (v.chk) begin
      chk({tag, ".req"}, 32'(imem.req), 32'(v.req));
      if (v.req) chk({tag, ".addr"}, imem.addr, v.addr);
      chk({tag, ".valid"}, 32'(o_valid), 32'(v.valid));
      chk({tag, ".instr"}, o_instr, v.valid ? mem_data(v.pc) : NOP_INSTR);
      chk({tag, ".pc"}, o_pc, v.pc);
      chk({tag, ".pc4"}, o_pc_four, v.four);
    end
    mem_lat = lat;
    advance();
  endtask

  vec_t t1[16];

  initial begin
    i_rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    imem.rvalid = 1'b0; imem.rdata = '0;

    // Reset release, 1-cycle memory, 5-cycle stall in HOLD.
    t1[0]  = mk(1,0,0,0, 0, 0,0,      0,0,0);
    t1[1]  = mk(1,0,0,0, 1, 0,0,      0,0,0);
    t1[2]  = mk(0,0,0,0, 1, 1,32'h0,  0,0,0);
    t1[3]  = mk(0,0,0,0, 1, 0,0,      0,0,0);
    t1[4]  = mk(0,0,0,0, 1, 0,0,      1,32'h0,32'h4);
    t1[5]  = mk(0,0,0,0, 1, 1,32'h4,  0,32'h0,32'h4);
    t1[6]  = mk(0,0,0,0, 1, 0,0,      0,32'h0,32'h4);
    for (int i = 7; i < 12; i++)
      t1[i] = mk(0,1,0,0, 1, 0,0,     1,32'h4,32'h8);
    t1[12] = mk(0,0,0,0, 1, 0,0,      1,32'h4,32'h8);
    t1[13] = mk(0,0,0,0, 1, 1,32'h8,  0,32'h4,32'h8);
    t1[14] = mk(0,0,0,0, 1, 0,0,      0,32'h4,32'h8);
    t1[15] = mk(0,1,0,0, 1, 0,0,      1,32'h8,32'hC);
    for (int i = 0; i < 16; i++) apply(t1[i], $sformatf("tbl[%0d]", i), 1);

    // Redirect in WAIT with 3-cycle memory: response drained, refetch at 0x100.
    apply(mk(1,0,0,0,          0, 0,0,0,0,0),                  "rw.rst0", 3);
    apply(mk(1,0,0,0,          1, 0,0,0,0,0),                  "rw.rst1", 3);
    apply(mk(0,0,0,0,          1, 1,32'h0,0,0,0),              "rw.req",  3);
    apply(mk(0,0,1,32'h102,    1, 0,0,0,0,0),                  "rw.redir",3);
    apply(mk(0,0,0,0,          1, 0,0,0,0,0),                  "rw.drain",3);
    apply(mk(0,0,0,0,          1, 0,0,0,0,0),                  "rw.drop", 3);
    apply(mk(0,0,0,0,          1, 1,32'h100,0,0,0),            "rw.refetch",3);
    apply(mk(0,0,0,0,          1, 0,0,0,0,0),                  "rw.w1",   3);
    apply(mk(0,0,0,0,          1, 0,0,0,0,0),                  "rw.w2",   3);
    apply(mk(0,0,0,0,          1, 0,0,0,0,0),                  "rw.w3",   3);
    apply(mk(0,0,0,0,          1, 0,0,1,32'h100,32'h104),      "rw.hold", 1);

    // Redirect coincident with the response: never presented, target next cycle.
    apply(mk(0,0,0,0,          1, 1,32'h104,0,32'h100,32'h104),"rc.req",  1);
    apply(mk(0,0,1,32'h200,    1, 0,0,0,32'h100,32'h104),      "rc.redir",1);
    apply(mk(0,0,0,0,          1, 1,32'h200,0,32'h100,32'h104),"rc.target",1);
    apply(mk(0,0,0,0,          1, 0,0,0,32'h100,32'h104),      "rc.wait", 1);
    apply(mk(0,0,0,0,          1, 0,0,1,32'h200,32'h204),      "rc.hold", 3);

    // Redirect in FETCH then again in DRAIN: one discard, fetch the later target.
    apply(mk(0,0,1,32'h40,     1, 1,32'h204,0,32'h200,32'h204),"rd.fetch",3);
    apply(mk(0,0,1,32'h80,     1, 0,0,0,32'h200,32'h204),      "rd.drain2",3);
    apply(mk(0,0,0,0,          1, 0,0,0,32'h200,32'h204),      "rd.d1",   3);
    apply(mk(0,0,0,0,          1, 0,0,0,32'h200,32'h204),      "rd.drop", 3);
    apply(mk(0,0,0,0,          1, 1,32'h80,0,32'h200,32'h204), "rd.req80",3);
    apply(mk(0,0,0,0,          1, 0,0,0,32'h200,32'h204),      "rd.w1",   3);
    apply(mk(0,0,0,0,          1, 0,0,0,32'h200,32'h204),      "rd.w2",   3);
    apply(mk(0,0,0,0,          1, 0,0,0,32'h200,32'h204),      "rd.w3",   3);
    apply(mk(0,0,0,0,          1, 0,0,1,32'h80,32'h84),        "rd.hold", 3);

    // Reset while waiting: outputs return to reset values, restart at RESET_PC.
    apply(mk(0,0,0,0,          1, 1,32'h84,0,32'h80,32'h84),   "rs.req",  3);
    apply(mk(1,0,1,32'h300,    1, 0,0,0,32'h80,32'h84),        "rs.rst",  3);
    apply(mk(0,0,0,0,          1, 1,TB_RESET_PC,0,0,0),        "rs.first",3);
    apply(mk(0,0,0,0,          1, 0,0,0,0,0),                  "rs.w1",   3);
    apply(mk(0,0,0,0,          1, 0,0,0,0,0),                  "rs.w2",   3);
    apply(mk(0,0,0,0,          1, 0,0,0,0,0),                  "rs.w3",   3);

    // Redirect in HOLD to the top word; PC+4 wraps to zero.
    apply(mk(0,1,1,32'hFFFF_FFFF,1, 0,0,1,32'h0,32'h4),        "wr.redir",1);
    apply(mk(0,0,0,0,          1, 1,32'hFFFF_FFFC,0,0,32'h4),  "wr.req",  1);
    apply(mk(0,0,0,0,          1, 0,0,0,0,32'h4),              "wr.wait", 1);
    apply(mk(0,0,0,0,          1, 0,0,1,32'hFFFF_FFFC,32'h0),  "wr.hold", 1);
    apply(mk(0,0,0,0,          1, 1,32'h0,0,32'hFFFF_FFFC,32'h0),"wr.next",1);

    // Randomized traffic against the reference model.
    rand_lat = 1'b1;
    spurious = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic        r, s, d;
      logic [31:0] t;
      r = ($urandom_range(0, 199) == 0);
      s = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 2))
        0:       t = $urandom;
        1:       t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: t = 32'($urandom_range(0, 255));
      endcase
      drive(r, s, d, t);
      model_check($sformatf("rnd[%0d]", c));
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
